// File: rtl/mem_alert_logger.sv
// mem_alert_logger: alert record FIFO with per-module saturating counters, sticky locks, irq and a Wishbone drain port
module mem_alert_logger #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8,
  parameter int THRESH_DEFAULT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alert_valid,
  input  logic [1:0]  alert_module_id,
  input  logic [3:0]  alert_addr,
  input  logic [3:0]  alert_data,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        irq,
  output logic [3:0]  module_lock
);
  localparam int AW = $clog2(DEPTH);
  logic [9:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] level;
  logic overflow, irq_en;
  logic [7:0] threshold;
  logic [CNT_W-1:0] cnt [4];
  logic [CNT_W-1:0] cnt_inc;
  logic [1:0] sel;
  logic empty, full, req, rd, wr, pop, push, flush, clr_cnt, clr_ovf, lock_hit;
  logic [31:0] status, counts, rdata;
  logic unused;
  assign unused = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i[31:19], wbs_dat_i[15:9]};
  assign sel = wbs_adr_i[3:2];
  assign empty = level == '0;
  assign full = level == (AW+1)'(DEPTH);
  assign req = wbs_cyc_i & wbs_stb_i & !wbs_ack_o;
  assign rd = req & !wbs_we_i;
  assign wr = req & wbs_we_i & (sel == 2'd3);
  assign pop = rd & (sel == 2'd1) & !empty;
  assign flush = wr & wbs_dat_i[18];
  assign clr_ovf = wr & wbs_dat_i[17];
  assign clr_cnt = wr & wbs_dat_i[16];
  assign push = alert_valid & (!full | pop) & !flush;
  assign cnt_inc = cnt[alert_module_id] + CNT_W'(cnt[alert_module_id] != '1);
  assign lock_hit = (threshold != 8'd0) && (32'(cnt_inc) >= 32'(threshold));
  assign irq = irq_en & (!empty | overflow);
  always_comb begin
    counts = '0;
    for (int i = 0; i < 4; i++) counts[8*i +: 8] = 8'(cnt[i]);
    status = {12'd0, module_lock, 5'd0, overflow, full, empty, 3'd0, 5'(level)};
    rdata = sel == 2'd0 ? status :
            sel == 2'd1 ? (empty ? 32'd0 : {1'b1, 21'd0, mem[rd_ptr]}) :
            sel == 2'd2 ? counts : {23'd0, irq_en, threshold};
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= {alert_data, alert_addr, alert_module_id};
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= !clr_ovf & (overflow | (alert_valid & full & !pop & !flush));
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        level <= level + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
      module_lock <= '0;
      threshold <= 8'(THRESH_DEFAULT);
      irq_en <= 1'b0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= rd ? rdata : '0;
      if (wr) begin
        threshold <= wbs_dat_i[7:0];
        irq_en <= wbs_dat_i[8];
      end
      if (clr_cnt) begin
        for (int i = 0; i < 4; i++) cnt[i] <= '0;
        module_lock <= '0;
      end else if (alert_valid) begin
        cnt[alert_module_id] <= cnt_inc;
        if (lock_hit) module_lock[alert_module_id] <= 1'b1;
      end
    end
  end
endmodule
